// File: rtl/global_bram_reader.sv
// Read-side streamer for the global BRAM: fetches a run of words starting at
// a base address and emits them in order on a valid/ready stream. A 2-entry
// output buffer absorbs the BRAM's 1-cycle read latency and back-pressure.
module global_bram_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FIN} state_t;

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_issued;
  logic                  r_inflight;
  logic                  r_infl_last;
  logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
  logic                  r_last0, r_last1;
  logic [1:0]            r_occ;

  logic                  w_pop;
  logic                  w_issue_last;
  logic                  w_accept;
  logic [2:0]            w_level;

  // Buffer head drives the stream directly; no path from rd_data.
  assign m_valid      = (r_occ != 2'd0);
  assign m_data       = r_buf0;
  assign m_last       = m_valid & r_last0;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_FIN);
  assign rd_addr      = r_base + r_issued[ADDR_WIDTH-1:0];
  assign w_pop        = m_valid & m_ready;
  assign w_issue_last = (r_issued == (r_len - ONE));
  assign w_accept     = (r_state == S_IDLE) & start;
  // Words that will sit in the buffer next cycle, counting the read in flight.
  assign w_level      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and read-issue decision.
  always_comb begin
    w_next = r_state;
    rd_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (length == '0) ? S_FIN : S_FETCH;
      end
      S_FETCH: begin
        rd_en = (w_level < 3'd2);
        if (rd_en && w_issue_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && m_last) w_next = S_FIN;
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: captured request, issue count and in-flight read tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_inflight  <= rd_en;
      r_infl_last <= rd_en & w_issue_last;
      if (w_accept) begin
        r_base   <= base_addr;
        r_len    <= length;
        r_issued <= '0;
      end else if (rd_en) begin
        r_issued <= r_issued + ONE;
      end
    end
  end

  // Two-entry FIFO: entry 0 is the head; returning read data is pushed behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_occ   <= 2'd0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0  <= rd_data;
            r_last0 <= r_infl_last;
          end else begin
            r_buf1  <= rd_data;
            r_last1 <= r_infl_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0  <= r_buf1;
          r_last0 <= r_last1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0  <= rd_data;
            r_last0 <= r_infl_last;
          end else begin
            r_buf0  <= r_buf1;
            r_last0 <= r_last1;
            r_buf1  <= rd_data;
            r_last1 <= r_infl_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_global_bram_reader.sv
// Directed bench for global_bram_reader: a 512-word BRAM model holding
// BRAM[i] = i + 100, transfers with fixed and toggling m_ready, address wrap,
// empty and full-depth transfers, ignored start and mid-transfer reset.
module tb_global_bram_reader;

  localparam int DW = 12;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  logic [DW-1:0] mem [512];
  logic [7:0]    pat = 8'b0101_1001;

  int n_vec = 0;
  int n_bad = 0;

  global_bram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // BRAM model: data appears the cycle after the read strobe.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // mode 0: m_ready held high; mode 1: m_ready follows a fixed toggle pattern.
  // inject: pulse a conflicting start while the transfer is busy.
  task automatic run_xfer(input int base, input int len, input int mode, input int inject);
    int c = 0, k = 0, nrd = 0, last_hs = 0, first_v = -1, max_occ = 0;
    int prev_data = 0, budget;
    bit prev_stall = 0, fin = 0;
    budget = len * 4 + 20;
    @(negedge clk);
    start     = 1'b1;
    base_addr = base[AW-1:0];
    length    = len[AW:0];
    m_ready   = (mode == 0) ? 1'b1 : pat[0];
    @(posedge clk);
    #1 start = 1'b0;
    while (!fin && c < budget) begin
      @(negedge clk);
      c++;
      m_ready = (mode == 0) ? 1'b1 : pat[c % 8];
      if (inject != 0 && c == 2) begin
        start = 1'b1; base_addr = 9'd300; length = 10'd7;
      end else begin
        start = 1'b0;
      end
      #1;
      if (c == 1) chk("busy_on", int'(busy), 1);
      if (prev_stall) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_data", int'(m_data), prev_data);
      end
      if (rd_en) begin
        chk("rd_addr", int'(rd_addr), (base + nrd) % 512);
        nrd++;
      end
      if (m_valid && first_v < 0) first_v = c;
      if (int'(dut.r_occ) > max_occ) max_occ = int'(dut.r_occ);
      if (m_valid && m_ready) begin
        chk("m_data", int'(m_data), ((base + k) % 512) + 100);
        chk("m_last", int'(m_last), (k == len - 1) ? 1 : 0);
        k++;
        last_hs = c;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = int'(m_data);
      if (done) begin
        fin = 1;
        chk("done_cycle", c, last_hs + 1);
        chk("busy_at_done", int'(busy), 1);
      end
    end
    if (!fin) chk("timeout", 0, 1);
    chk("word_count", k, len);
    chk("read_count", nrd, len);
    chk("occ_max_le2", (max_occ <= 2) ? 1 : 0, 1);
    if (len == 0) chk("no_valid", first_v, -1);
    if (mode == 0 && len > 0) begin
      chk("first_valid", first_v, 3);
      chk("last_hs", last_hs, len + 2);
    end
    @(negedge clk);
    #1;
    chk("busy_off", int'(busy), 0);
    chk("done_off", int'(done), 0);
  endtask

  initial begin
    int hs, guard;
    for (int i = 0; i < 512; i++) mem[i] = DW'(i + 100);
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    @(negedge clk);
    rst = 1'b0;

    run_xfer(0, 4, 0, 0);     // T1 fill
    run_xfer(20, 8, 1, 0);    // T2 back-pressure
    run_xfer(510, 4, 0, 0);   // T3 wrap
    run_xfer(0, 0, 0, 0);     // T4 empty
    run_xfer(0, 512, 0, 0);   // T5 full depth
    run_xfer(40, 5, 1, 1);    // T6a start while busy

    // T6b: reset after three words have been handed off
    @(negedge clk);
    start = 1'b1; base_addr = 9'd0; length = 10'd10; m_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hs = 0; guard = 0;
    while (hs < 3 && guard < 50) begin
      @(negedge clk);
      #1;
      if (m_valid && m_ready) hs++;
      guard++;
    end
    chk("abort_reach3", hs, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_rd_en", int'(rd_en), 0);
    chk("abort_rd_addr", int'(rd_addr), 0);
    chk("abort_m_valid", int'(m_valid), 0);
    chk("abort_m_data", int'(m_data), 0);
    chk("abort_m_last", int'(m_last), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_no_done", int'(done), 0);
    run_xfer(5, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
